// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the block-RAM arbiter slice.
//   state_t  : arbiter FSM state (IDLE -> ACCESS -> RESP -> IDLE)
//   MAX_REQ  : largest number of requesters the arbiter is built for
//   idx_w()  : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index width for n requesters; never less than one bit so that a
  // two-requester build still gets a real index signal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches the request vector upward from
// last_i+1, wrapping modulo NUM_REQ, and reports the first set bit.
//   req_i  : request vector, one bit per requester
//   last_i : index of the requester granted most recently
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   idx_o  : index of the granted requester (0 when nothing requests)
//   any_o  : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester exactly once, ending on the
  // previous winner itself, so a lone requester always wins regardless of
  // where the pointer stands.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = int'(last_i) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      cand = IDX_W'(pos);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, byte-writable block RAM between NUM_REQ requesters.
// One request is accepted at a time (valid/ready), driven to the RAM for one
// cycle, and answered with a one-cycle response pulse to its owner.
//
// Parameters
//   NUM_REQ : requesters, 2..8
//   ADDR_W  : word address width
//   DATA_W  : data width, multiple of 8 (BE_W = DATA_W/8 byte enables)
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_valid_i  : per-requester request valid
//   req_ready_o  : one-hot accept for the arbitration winner (IDLE only)
//   req_addr_i   : flat addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_wdata_i  : flat write data, requester k at [k*DATA_W +: DATA_W]
//   req_we_i     : flat byte enables, requester k at [k*BE_W +: BE_W];
//                  all zero selects a read
//   rsp_valid_o  : one-hot, one-cycle response pulse (reads and writes)
//   rsp_rdata_o  : read data, zero for write acknowledges and outside RESP
//   mem_en_o     : RAM enable, high only in ACCESS
//   mem_we_o     : RAM byte enables, nonzero only in ACCESS
//   mem_addr_o   : RAM address, holds the latched request address
//   mem_wdata_o  : RAM write data, holds the latched request data
//   mem_rdata_i  : RAM read data, valid one cycle after the enabled edge
//
// Timing: accept at T (IDLE), RAM access at T+1, response at T+2, next
// accept at T+3 at the earliest.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = 10,
  parameter  int DATA_W  = 32,
  localparam int BE_W    = DATA_W / 8,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]   req_we_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      mem_en_o,
  output logic [BE_W-1:0]           mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  // ---------------------------------------------------------------------------
  // Per-requester views of the flat request buses
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [BE_W-1:0]   we_arr    [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
    assign we_arr[k]    = req_we_i[k*BE_W +: BE_W];
  end

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_we;
  logic              accept;

  // ---------------------------------------------------------------------------
  // Round-robin pick over the live valid vector
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               any_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_grant),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .any_o  (any_valid)
  );

  // ---------------------------------------------------------------------------
  // State register and request latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      lat_idx    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_idx   <= win_idx;
        lat_addr  <= addr_arr[win_idx];
        lat_wdata <= wdata_arr[win_idx];
        lat_we    <= we_arr[win_idx];
      end
      // The pointer moves only once the response is delivered, so a
      // transaction abandoned by reset leaves no trace in the rotation.
      if (state == RESP) begin
        last_grant <= lat_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = IDLE;
    accept      = 1'b0;
    req_ready_o = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;

    case (state)
      IDLE: begin
        // The winner is picked from the valid vector, so a raised ready
        // always meets a raised valid: any_valid is the handshake itself.
        // Ready is held low while reset is asserted, since the edge will
        // not take the request.
        if (!rst_i) begin
          req_ready_o = win_gnt;
        end
        if (any_valid) begin
          state_nxt = ACCESS;
          accept    = 1'b1;
        end
      end

      ACCESS: begin
        mem_en_o  = 1'b1;
        mem_we_o  = lat_we;
        state_nxt = RESP;
      end

      RESP: begin
        rsp_valid_o = NUM_REQ'(1) << lat_idx;
        if (lat_we == '0) begin
          rsp_rdata_o = mem_rdata_i;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address and write data stay on the latched values in every state so the
  // RAM pins only change when a new request is accepted.
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter built with four requesters. A simple
// registered RAM sits on the memory port; a transaction-level reference
// (phase counter, modulo-N round-robin search, shadow memory) predicts every
// output on every cycle. Directed scenarios come first, then random traffic
// with occasional reset pulses.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*BW-1:0]   req_we_i;
  logic [N-1:0]      rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              mem_en_o;
  logic [BW-1:0]     mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [DW-1:0]     mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_we_i    (req_we_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Registered-output RAM on the memory port.
  logic [DW-1:0] ram [1024];

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o == '0) begin
        mem_rdata_i <= ram[mem_addr_o];
      end else begin
        for (int b = 0; b < BW; b++) begin
          if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow [1024];
  int            m_phase;   // 0 waiting, 1 RAM cycle, 2 response cycle
  int            m_last;
  int            m_k;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_we;

  // Observed values of the most recent cycle, for directed checks.
  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rsp;
  logic          obs_en;
  logic [BW-1:0] obs_we;
  logic [DW-1:0] obs_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic drive(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] we);
    req_addr_i[k*AW +: AW]  = a;
    req_wdata_i[k*DW +: DW] = d;
    req_we_i[k*BW +: BW]    = we;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  // One clock: check every output at the falling edge against the model,
  // advance the model to the state after the next rising edge, then move
  // to just after that edge so the caller can change inputs.
  task automatic cycle();
    int            win;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_rsp;
    logic          e_en;
    logic [BW-1:0] e_we;
    logic [DW-1:0] e_rdata;

    @(negedge clk_i);
    win     = rr_pick(req_valid_i, m_last);
    e_ready = '0;
    e_rsp   = '0;
    e_en    = 1'b0;
    e_we    = '0;
    e_rdata = '0;
    if (m_phase == 0 && !rst_i && win >= 0) e_ready[win] = 1'b1;
    if (m_phase == 1) begin
      e_en = 1'b1;
      e_we = m_we;
    end
    if (m_phase == 2) begin
      e_rsp[m_k] = 1'b1;
      if (m_we == '0) e_rdata = shadow[m_addr];
    end

    check("req_ready", 32'(req_ready_o), 32'(e_ready));
    check("mem_en",    32'(mem_en_o),    32'(e_en));
    check("mem_we",    32'(mem_we_o),    32'(e_we));
    check("mem_addr",  32'(mem_addr_o),  32'(m_addr));
    check("mem_wdata", mem_wdata_o,      m_wdata);
    check("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
    check("rsp_rdata", rsp_rdata_o,      e_rdata);

    obs_ready = req_ready_o;
    obs_rsp   = rsp_valid_o;
    obs_en    = mem_en_o;
    obs_we    = mem_we_o;
    obs_rdata = rsp_rdata_o;

    // The RAM sees the enabled write on this edge even if reset is asserted.
    if (m_phase == 1) begin
      for (int b = 0; b < BW; b++) begin
        if (m_we[b]) shadow[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      end
    end

    if (rst_i) begin
      m_phase = 0;
      m_last  = N - 1;
      m_k     = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_we    = '0;
    end else if (m_phase == 0) begin
      if (win >= 0) begin
        m_k     = win;
        m_addr  = req_addr_i[win*AW +: AW];
        m_wdata = req_wdata_i[win*DW +: DW];
        m_we    = req_we_i[win*BW +: BW];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_last  = m_k;
      m_phase = 0;
    end

    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rst_i       = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    int cnt;

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_we_i    = '0;
    for (int i = 0; i < 1024; i++) preload(AW'(i), $urandom);
    m_phase = 0;
    m_last  = N - 1;
    m_k     = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state, then requester 0 reads 0x005.
    do_reset();
    preload(10'h005, 32'hDEADBEEF);
    drive(0, 10'h005, 32'h0, 4'b0000);
    req_valid_i = 4'b0001;
    cycle();
    check("d1_ready", 32'(obs_ready), 32'h1);
    req_valid_i = '0;
    cycle();
    check("d1_en", 32'(obs_en), 32'h1);
    check("d1_we", 32'(obs_we), 32'h0);
    cycle();
    check("d1_rsp", 32'(obs_rsp), 32'h1);
    check("d1_rdata", obs_rdata, 32'hDEADBEEF);

    // Requester 1 byte-writes 0x00A, then reads it back.
    preload(10'h00A, 32'hAABBCCDD);
    drive(1, 10'h00A, 32'h11223344, 4'b0101);
    req_valid_i = 4'b0010;
    cycle();
    check("d2_ready", 32'(obs_ready), 32'h2);
    req_valid_i = '0;
    cycle();
    check("d2_we", 32'(obs_we), 32'h5);
    cycle();
    check("d2_ack", 32'(obs_rsp), 32'h2);
    check("d2_ack_rdata", obs_rdata, 32'h0);
    drive(1, 10'h00A, 32'h0, 4'b0000);
    req_valid_i = 4'b0010;
    cycle();
    req_valid_i = '0;
    cycle();
    cycle();
    check("d2_rdata", obs_rdata, 32'hAA22CC44);

    // Continuous contention between requesters 0 and 1 from reset.
    do_reset();
    drive(0, 10'h001, 32'h0, 4'b0000);
    drive(1, 10'h002, 32'h0, 4'b0000);
    req_valid_i = 4'b0011;
    cnt = 0;
    for (int c = 0; c < 18; c++) begin
      cycle();
      if (obs_ready != '0) begin
        check("rr_order", 32'(obs_ready), 32'(1) << (cnt % 2));
        cnt++;
      end
    end
    check("rr_count", 32'(cnt), 32'd6);
    req_valid_i = '0;

    // After a grant to 3, with 2 and 3 valid: 2 wins, then 3.
    do_reset();
    drive(2, 10'h003, 32'h0, 4'b0000);
    drive(3, 10'h004, 32'h0, 4'b0000);
    req_valid_i = 4'b1000;
    cycle();
    check("d4_first", 32'(obs_ready), 32'h8);
    req_valid_i = '0;
    cycle();
    cycle();
    req_valid_i = 4'b1100;
    cycle();
    check("d4_second", 32'(obs_ready), 32'h4);
    cycle();
    cycle();
    cycle();
    check("d4_third", 32'(obs_ready), 32'h8);
    req_valid_i = '0;
    cycle();
    cycle();

    // Reset during the RAM cycle of a read abandons it.
    drive(1, 10'h006, 32'h0, 4'b0000);
    req_valid_i = 4'b0010;
    cycle();
    req_valid_i = '0;
    rst_i       = 1'b1;
    cycle();
    rst_i = 1'b0;
    cycle();
    check("d5_en", 32'(obs_en), 32'h0);
    check("d5_rsp", 32'(obs_rsp), 32'h0);
    drive(0, 10'h007, 32'h0, 4'b0000);
    req_valid_i = 4'b0011;
    cycle();
    check("d5_next", 32'(obs_ready), 32'h1);

    // A valid pulse seen only during RESP is never accepted.
    req_valid_i = '0;
    cycle();
    req_valid_i = 4'b0001;
    cycle();
    check("d6_ready", 32'(obs_ready), 32'h0);
    req_valid_i = '0;
    cycle();
    check("d6_idle", 32'(obs_en), 32'h0);
    cycle();
    check("d6_noacc", 32'(obs_en), 32'h0);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int c = 0; c < 3000; c++) begin
      rst_i       = ($urandom_range(0, 63) == 0);
      req_valid_i = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req_valid_i = '0;
      for (int k = 0; k < N; k++) begin
        drive(k, AW'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 1) == 1) ? BW'($urandom) : '0);
      end
      cycle();
    end
    rst_i       = 1'b0;
    req_valid_i = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-port, byte-writable block RAM between `NUM_REQ` requesters (e.g. core load/store port and DMA engine). It accepts one request at a time over a valid/ready handshake, sequences the RAM enable and byte write-enables, and routes the read data or write acknowledge back to the winning requester. It sits between the requester ports and the RAM primitive, in the same layer as the single-requester memory controller.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..8.
- `ADDR_W`, 10: word address width.
- `DATA_W`, 32: data width; must be a multiple of 8. Byte-enable width is `BE_W = DATA_W/8`.

- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: request valid, one bit per requester.
- `req_ready_o` out NUM_REQ: one-hot accept for the winner; never more than one bit set.
- `req_addr_i` in NUM_REQ*ADDR_W: flat per-requester address; requester k uses slice [k*ADDR_W +: ADDR_W].
- `req_wdata_i` in NUM_REQ*DATA_W: flat per-requester write data.
- `req_we_i` in NUM_REQ*BE_W: per-requester byte write-enables; all zero means read.
- `rsp_valid_o` out NUM_REQ: one-hot, one-cycle response pulse.
- `rsp_rdata_o` out DATA_W: read data, shared by all requesters; qualified by `rsp_valid_o`.
- `mem_en_o` out 1: RAM enable.
- `mem_we_o` out BE_W: RAM byte write-enables.
- `mem_addr_o` out ADDR_W: RAM address.
- `mem_wdata_o` out DATA_W: RAM write data.
- `mem_rdata_i` in DATA_W: RAM read data; registered, available 1 cycle after the enabled edge.

## Operation
- FSM states are IDLE, ACCESS and RESP.
  - IDLE → ACCESS when any `req_valid_i` is set; otherwise stay in IDLE.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
  - Any illegal encoding → IDLE.
- Arbitration happens only in IDLE.
  - Winner is the first set `req_valid_i` bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `req_ready_o[winner]` is asserted combinationally in that same cycle; the handshake completes when valid and ready are both high.
  - On acceptance, latch the winner index, address, wdata and byte-enables into internal registers.
- ACCESS:
  - `mem_en_o`=1.
  - `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven from the latched values.
- RESP:
  - `rsp_valid_o[winner]`=1 for both reads and writes; a write gets an acknowledge.
  - `rsp_rdata_o` = `mem_rdata_i` for a read, 0 for a write.
  - `last_grant` ← winner.
- Outside ACCESS: `mem_en_o`=0 and `mem_we_o`=0. `mem_addr_o`/`mem_wdata_o` keep the latched values (no toggling).
- Outside RESP: `rsp_valid_o`=0 and `rsp_rdata_o`=0.
- `req_ready_o`=0 in ACCESS and RESP; requesters stall there.
- A requester may deassert valid before acceptance without side effects. After acceptance, its input values are don't-care.
- Reset values:
  - state=IDLE, `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - All latched fields 0.
  - All outputs 0, except that `req_ready_o` may rise in the first IDLE cycle after reset release.

## Timing
- Accept at cycle T (IDLE) → `mem_en_o` at T+1 → `rsp_valid_o` at T+2 → next accept at T+3 at the earliest.
- Latency from accept to response is 2 cycles. Throughput is 1 transaction per 3 cycles.
- Simultaneous valids: strictly alternating grants under continuous contention; no requester waits more than NUM_REQ-1 transactions.
- Only one requester valid: it is granted immediately, regardless of `last_grant`.
- Reset asserted in ACCESS or RESP:
  - Transaction is abandoned; no `rsp_valid_o` pulse.
  - `mem_en_o`/`mem_we_o` are 0 in the cycle after the reset edge.
  - `last_grant` returns to NUM_REQ-1.
- Valid dropped in the same cycle ready rises: counts as not accepted (needs both high). FSM stays in IDLE and re-arbitrates next cycle.

## Structure
- Package `mem_arb_pkg`: `state_t` enum (IDLE, ACCESS, RESP), plus the `MAX_REQ=8` constant and an index-width function (`$clog2`-based).
- Sub-module `rr_arbiter`: combinational round-robin picker.
  - Inputs: request vector, `last_grant` pointer.
  - Outputs: one-hot grant, winner index, any-valid.
- FSM, latches and output muxing stay in `mem_arbiter`.

## Test plan
- Reset, then req0 reads addr 0x005 holding 0xDEADBEEF → `req_ready_o`=01 at T, `mem_en_o`=1/`mem_we_o`=0 at T+1, `rsp_valid_o`=01 with `rsp_rdata_o`=0xDEADBEEF at T+2.
- req1 writes 0x11223344 with `req_we_i`=4'b0101 to 0x00A, then reads 0x00A (prior content 0xAABBCCDD) → `mem_we_o`=0101 in ACCESS, write-ack pulse with rdata 0, read returns 0xAA22CC44.
- req0 and req1 valid continuously for 6 transactions from reset → grant order 0,1,0,1,0,1; each `rsp_valid_o` goes only to the granted bit.
- `NUM_REQ`=4, only req2 and req3 valid after a grant to req3 → req2 wins next, then req3.
- `rst_i` pulsed during ACCESS of a read → no `rsp_valid_o`, `mem_en_o`=0 the next cycle, next grant goes to req0.
- req0 valid for one cycle while the FSM is in RESP, then low → no grant, no memory access, FSM stays in IDLE.
